// File: rtl/cmdparse_pkg.sv
// Shared types and helpers for the cmdparse frame parser.
// CRC-8 helper is used only when CMDPARSE_CRC_EN is defined.
package cmdparse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADRH,
        S_ADRL,
        S_DAT,
        S_CHK
    } state_t;

    localparam int HDR_WE      = 7;
    localparam int HDR_SEQ_MSB = 5;
    localparam int HDR_SEQ_LSB = 0;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first CRC-8, no reflection, one byte per call.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/cmdparse_if.sv
// Byte-stream input and request/error outputs of the cmdparse block.
// The parser uses the slave modport; the byte source uses master.
interface cmdparse_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        req_stb;
    logic [5:0]  req_seq;
    logic        req_we;
    logic [15:0] req_adr;
    logic [7:0]  req_dat;
    logic [7:0]  err_count;

    modport master (
        output rx_data, rx_valid,
        input  req_stb, req_seq, req_we, req_adr, req_dat, err_count
    );

    modport slave (
        input  rx_data, rx_valid,
        output req_stb, req_seq, req_we, req_adr, req_dat, err_count
    );
endinterface

// File: rtl/cmdparse_timeout.sv
// Inter-byte idle counter: cleared by clr, counts while en, and flags
// expiry on the cycle the count would reach TIMEOUT_CYCLES.
module cmdparse_timeout #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + W'(1);
    end

    // A clear in the same cycle (arriving byte) suppresses expiry.
    assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/cmdparse.sv
// Command frame parser: SYNC, HDR, ADR_HI, ADR_LO, DAT [, CHK].
// Define CMDPARSE_CRC_EN to build the CHK byte and CRC-8 check.
module cmdparse
    import cmdparse_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic      clk,
    input  logic      rst,
    cmdparse_if.slave bus
);
    state_t      state, state_nxt;
    logic        fire, drop, expired;
    logic        hdr_we;
    logic [5:0]  hdr_seq;
    logic [7:0]  adrh, adrl;
`ifdef CMDPARSE_CRC_EN
    logic [7:0]  dat;
    logic [7:0]  crc;
`endif

    cmdparse_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rx_valid || state == S_IDLE),
        .en      (state != S_IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        drop      = 1'b0;
        if (bus.rx_valid) begin
            case (state)
                S_IDLE: if (bus.rx_data == SYNC_BYTE) state_nxt = S_HDR;
                S_HDR:  state_nxt = S_ADRH;
                S_ADRH: state_nxt = S_ADRL;
                S_ADRL: state_nxt = S_DAT;
`ifdef CMDPARSE_CRC_EN
                S_DAT:  state_nxt = S_CHK;
                S_CHK: begin
                    state_nxt = S_IDLE;
                    if (bus.rx_data == crc) fire = 1'b1;
                    else                    drop = 1'b1;
                end
`else
                S_DAT: begin
                    state_nxt = S_IDLE;
                    fire      = 1'b1;
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end else if (expired) begin
            state_nxt = S_IDLE;
            drop      = 1'b1;
        end
    end

    // Staging registers; SYNC inside the frame is ordinary payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_we  <= 1'b0;
            hdr_seq <= '0;
            adrh    <= '0;
            adrl    <= '0;
`ifdef CMDPARSE_CRC_EN
            dat     <= '0;
            crc     <= '0;
`endif
        end else if (bus.rx_valid) begin
            case (state)
                S_HDR: begin
                    hdr_we  <= bus.rx_data[HDR_WE];
                    hdr_seq <= bus.rx_data[HDR_SEQ_MSB:HDR_SEQ_LSB];
                end
                S_ADRH: adrh <= bus.rx_data;
                S_ADRL: adrl <= bus.rx_data;
`ifdef CMDPARSE_CRC_EN
                S_DAT:  dat  <= bus.rx_data;
`endif
                default: ;
            endcase
`ifdef CMDPARSE_CRC_EN
            crc <= (state == S_IDLE) ? 8'h00 : crc8_byte(crc, bus.rx_data);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req_stb   <= 1'b0;
            bus.req_seq   <= '0;
            bus.req_we    <= 1'b0;
            bus.req_adr   <= '0;
            bus.req_dat   <= '0;
            bus.err_count <= '0;
        end else begin
            bus.req_stb <= fire;
            if (fire) begin
                bus.req_seq <= hdr_seq;
                bus.req_we  <= hdr_we;
                bus.req_adr <= {adrh, adrl};
`ifdef CMDPARSE_CRC_EN
                bus.req_dat <= dat;
`else
                bus.req_dat <= bus.rx_data;
`endif
            end
            if (drop && bus.err_count != 8'hFF)
                bus.err_count <= bus.err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmdparse.sv
// Bench for cmdparse: directed frames with literal expectations plus
// random byte streams compared every cycle against a queue-based model.
module tb_cmdparse;
    localparam int         T    = 16;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef CMDPARSE_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam int PAY = CRC_ON ? 5 : 4;

    logic clk = 1'b0;
    logic rst;
    cmdparse_if bus ();

    cmdparse #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as remainder of msg*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc_of(input logic [31:0] msg);
        logic [39:0] m;
        m = {msg, 8'h00};
        for (int i = 39; i >= 8; i--)
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        return m[7:0];
    endfunction

    // Reference model: collect frame bytes in a queue, judge on completion.
    logic [7:0]  q[$];
    bit          m_in;
    int          m_idle;
    bit          m_stb, m_we;
    logic [5:0]  m_seq;
    logic [15:0] m_adr;
    logic [7:0]  m_dat, m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_in = 0; q.delete(); m_idle = 0;
            m_stb = 0; m_we = 0; m_seq = 0; m_adr = 0; m_dat = 0; m_err = 0;
        end else begin
            m_stb = 0;
            if (bus.rx_valid) begin
                m_idle = 0;
                if (!m_in) begin
                    if (bus.rx_data == SYNC) begin m_in = 1; q.delete(); end
                end else begin
                    q.push_back(bus.rx_data);
                    if (q.size() == PAY) begin
                        bit good;
                        m_in = 0;
                        good = 1;
                        if (CRC_ON) good = (crc_of({q[0], q[1], q[2], q[3]}) == q[PAY-1]);
                        if (good) begin
                            m_stb = 1; m_we = q[0][7]; m_seq = q[0][5:0];
                            m_adr = {q[1], q[2]}; m_dat = q[3];
                        end else if (m_err != 8'hFF) m_err = m_err + 1;
                    end
                end
            end else if (m_in) begin
                m_idle++;
                if (m_idle == T) begin
                    m_in = 0; m_idle = 0;
                    if (m_err != 8'hFF) m_err = m_err + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_stb", bus.req_stb, m_stb);
            chk("m_seq", bus.req_seq, m_seq);
            chk("m_we",  bus.req_we,  m_we);
            chk("m_adr", bus.req_adr, m_adr);
            chk("m_dat", bus.req_dat, m_dat);
            chk("m_err", bus.err_count, m_err);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] h, ah, al, d, input bit bad, input int gap);
        logic [7:0] c;
        send(SYNC);
        if (gap > 0) idle($urandom_range(0, gap)); send(h);
        if (gap > 0) idle($urandom_range(0, gap)); send(ah);
        if (gap > 0) idle($urandom_range(0, gap)); send(al);
        if (gap > 0) idle($urandom_range(0, gap)); send(d);
        if (CRC_ON) begin
            c = crc_of({h, ah, al, d}) ^ {7'd0, bad};
            if (gap > 0) idle($urandom_range(0, gap));
            send(c);
        end
    endtask

    task automatic expect_req(input string tag, input logic stb, input logic we,
                              input logic [5:0] seq, input logic [15:0] adr,
                              input logic [7:0] dat, input logic [7:0] err);
        chk({tag, "_stb"}, bus.req_stb, stb);
        chk({tag, "_we"},  bus.req_we,  we);
        chk({tag, "_seq"}, bus.req_seq, seq);
        chk({tag, "_adr"}, bus.req_adr, adr);
        chk({tag, "_dat"}, bus.req_dat, dat);
        chk({tag, "_err"}, bus.err_count, err);
    endtask

    int errbase;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        idle(1);
        expect_req("reset", 0, 0, 6'h00, 16'h0000, 8'h00, 8'h00);
        rst = 1'b0;
        idle(2);

        // Good write frame, back-to-back bytes
        send(8'hA5); send(8'h80); send(8'h12); send(8'h34); send(8'h56);
        if (CRC_ON) send(8'h4D);
        expect_req("good", 1, 1, 6'h00, 16'h1234, 8'h56, 8'h00);
        idle(1);
        chk("good_pulse", bus.req_stb, 1'b0);

        errbase = 0;
        if (CRC_ON) begin
            send(8'hA5); send(8'h80); send(8'h12); send(8'h34); send(8'h56); send(8'h4E);
            chk("badcrc_stb", bus.req_stb, 1'b0);
            chk("badcrc_err", bus.err_count, 8'h01);
            errbase = 1;
        end
        idle(3);
        frame(8'hC5, 8'hAB, 8'hCD, 8'hEF, 0, 0);
        expect_req("after", 1, 1, 6'h05, 16'hABCD, 8'hEF, 8'(errbase));

        // Noise then sync bytes used as payload
        send(8'h00); send(8'hFF); send(8'h5A);
        frame(8'h80, 8'hA5, 8'hA5, 8'hA5, 0, 0);
        expect_req("sync_pay", 1, 1, 6'h00, 16'hA5A5, 8'hA5, 8'(errbase));

        // Timeout, then a byte landing exactly on the expiry cycle
        send(8'hA5); send(8'h80); send(8'h12);
        idle(T);
        chk("tmo_err", bus.err_count, 8'(errbase + 1));
        send(8'h34); send(8'h56);
        if (CRC_ON) send(8'h4D);
        chk("tmo_nostb", bus.req_stb, 1'b0);
        send(8'hA5); send(8'h81); send(8'h12);
        idle(T - 1);
        send(8'h34); send(8'h57);
        if (CRC_ON) send(crc_of(32'h81123457));
        expect_req("edge", 1, 1, 6'h01, 16'h1234, 8'h57, 8'(errbase + 1));

        // Reset mid-frame
        send(8'hA5); send(8'h80);
        rst = 1'b1;
        idle(1);
        expect_req("midrst", 0, 0, 6'h00, 16'h0000, 8'h00, 8'h00);
        rst = 1'b0;
        frame(8'h3F, 8'hBE, 8'hEF, 8'h11, 0, 0);
        expect_req("postrst", 1, 0, 6'h3F, 16'hBEEF, 8'h11, 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 2)       send(8'($urandom_range(0, 255)));
            else if (r < 4)  idle($urandom_range(0, 20));
            else if (r == 4) begin rst = 1'b1; idle(1); rst = 1'b0; end
            else frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0) ? 20 : 0);
        end

        // Saturation
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int n = 0; n < 260; n++) begin
            send(SYNC);
            idle(T);
        end
        chk("sat_err", bus.err_count, 8'hFF);
        chk("sat_stb", bus.req_stb, 1'b0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
